// File: rtl/onehot_steer.sv
// onehot_steer: steers a request to one of N = 2**SEL_W outputs as a registered
// one-hot vector, held for a per-request number of cycles.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   in_valid    request present
//   in_sel      requested output index (SEL_W bits)
//   in_hold     hold length in cycles, 0 behaves as 1 (HOLD_W bits)
//   in_ready    combinational: a request can be accepted this cycle
//   out_onehot  registered one-hot steering vector (N bits)
//   busy        registered: high while a request is being held
//   cur_idx     registered binary index of the set out_onehot bit
module onehot_steer #(
    parameter int SEL_W       = 2,
    parameter int HOLD_W      = 4,
    parameter int DEFAULT_IDX = 0,
    parameter int STICKY      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic [HOLD_W-1:0]   in_hold,
    output logic                in_ready,
    output logic [2**SEL_W-1:0] out_onehot,
    output logic                busy,
    output logic [SEL_W-1:0]    cur_idx
);

    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] DEF = SEL_W'(DEFAULT_IDX);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_n;
    logic [SEL_W-1:0]  idx_n;
    logic              busy_n;
    logic [N-1:0]      oh_n;
    logic              last;
    logic              accept;

    // State register: every output bit is a flop, so the one-hot vector
    // never glitches through zero or multi-hot between cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            cur_idx    <= DEF;
            out_onehot <= N'(1) << DEF;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            busy       <= busy_n;
            cur_idx    <= idx_n;
            out_onehot <= oh_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = busy;
        idx_n   = cur_idx;
        if (accept) begin
            // A new request wins over expiry, giving back-to-back holds.
            state_n = DRIVE;
            cnt_n   = (in_hold == '0) ? HOLD_W'(1) : in_hold;
            busy_n  = 1'b1;
            idx_n   = in_sel;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                DRIVE: begin
                    cnt_n = cnt - HOLD_W'(1);
                    if (last) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        idx_n   = (STICKY != 0) ? cur_idx : DEF;
                    end
                end
            endcase
        end
        oh_n = N'(1) << idx_n;
    end

    // Output logic: readiness opens on the final hold cycle so a follow-on
    // request lands with no idle gap.
    always_comb begin
        last     = (cnt == HOLD_W'(1));
        in_ready = (state == IDLE) || last;
        accept   = in_valid && in_ready;
    end

endmodule
